// File: rtl/pe_inst_sequencer_if.sv
// pe_inst_sequencer_if: config write handshake and PE instruction bus between array config, sequencer and PE
interface pe_inst_sequencer_if #(
  parameter int INST_W = 45,
  parameter int AW = 4
);
  logic cfg_valid;
  logic cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [INST_W-1:0] cfg_data;
  logic [INST_W-1:0] inst;
  logic inst_valid;
  modport master(output cfg_valid, cfg_addr, cfg_data, input cfg_ready, inst, inst_valid);
  modport slave(input cfg_valid, cfg_addr, cfg_data, output cfg_ready, inst, inst_valid);
endinterface

// File: rtl/pe_inst_sequencer.sv
// pe_inst_sequencer: per-PE context memory replayed into the PE instruction input for a programmed number of iterations
module pe_inst_sequencer #(
  parameter int INST_W = 45,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH),
  parameter int ITER_W = 16
) (
  input  logic clk,
  input  logic rst,
  pe_inst_sequencer_if.slave bus,
  input  logic start,
  input  logic [AW:0] ctx_len,
  input  logic [ITER_W-1:0] iter_cnt,
  input  logic stall,
  input  logic abort,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [INST_W-1:0] mem [DEPTH];
  logic [AW:0] len;
  logic [AW:0] slen;
  logic [AW-1:0] pc;
  logic [ITER_W-1:0] iters;
  logic [ITER_W-1:0] it;
  logic last;
  assign slen = ctx_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : ctx_len;
  assign bus.cfg_ready = (state == IDLE) && !start;
  // pc points at the next slot to issue, it is the iteration of the word on inst;
  // pc back at 0 means slot len-1 was just issued
  assign last = (pc == '0) && (it == iters - ITER_W'(1));
  // context memory write port, deliberately not reset
  always_ff @(posedge clk)
    if (bus.cfg_valid && bus.cfg_ready) mem[bus.cfg_addr] <= bus.cfg_data;
  // sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.inst <= '0;
      bus.inst_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pc <= '0;
      it <= '0;
      len <= '0;
      iters <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            len <= slen;
            iters <= iter_cnt;
            if (slen == '0 || iter_cnt == '0) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= RUN;
              busy <= 1'b1;
              bus.inst <= mem[0];
              bus.inst_valid <= 1'b1;
              pc <= slen == (AW+1)'(1) ? '0 : AW'(1);
              it <= '0;
            end
          end
        end
        RUN: begin
          if (abort || (!stall && last)) begin
            state <= abort ? IDLE : DONE;
            done <= !abort;
            busy <= 1'b0;
            bus.inst <= '0;
            bus.inst_valid <= 1'b0;
          end else if (!stall) begin
            bus.inst <= mem[pc];
            pc <= {1'b0, pc} == len - (AW+1)'(1) ? '0 : pc + AW'(1);
            it <= pc == '0 ? it + ITER_W'(1) : it;
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          bus.inst <= '0;
          bus.inst_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
